// File: rtl/axi_counter_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_counter_master
//  Description : AXI master that fills SLOTS slave registers with an
//                arithmetic counter sequence (single-beat writes), reads the
//                slave XOR checksum back and flags any write-response error
//                or checksum disagreement.
//                Optional handshake watchdog: define AXI_MASTER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_counter_master #(
   parameter int          DATA_WIDTH     = 32,
   parameter int          ADDR_WIDTH     = 32,
   parameter int          SLOTS          = 8,
   parameter logic [31:0] CRC_ADDR       = 32'h20,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   input  logic [DATA_WIDTH-1:0] step_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [DATA_WIDTH-1:0] crc_o,
   output logic [3:0]            awid_o,
   output logic [3:0]            wid_o,
   output logic [3:0]            arid_o,
   output logic [3:0]            awlen_o,
   output logic [2:0]            awsize_o,
   output logic [1:0]            awburst_o,
   output logic [ADDR_WIDTH-1:0] awaddr_o,
   output logic                  awvalid_o,
   input  logic                  awready_i,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic [3:0]            wstrb_o,
   output logic                  wlast_o,
   output logic                  wvalid_o,
   input  logic                  wready_i,
   input  logic [3:0]            bid_i,
   input  logic [1:0]            bresp_i,
   input  logic                  bvalid_i,
   output logic                  bready_o,
   output logic [ADDR_WIDTH-1:0] araddr_o,
   output logic                  arvalid_o,
   input  logic                  arready_i,
   input  logic [3:0]            rid_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic                  rlast_i,
   input  logic                  rvalid_i,
   output logic                  rready_o
);

   localparam int IDX_W = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_WRESP = 3'd2,
      S_RADDR = 3'd3,
      S_RDATA = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic [DATA_WIDTH-1:0] step_q,  step_d;
   logic [DATA_WIDTH-1:0] acc_q,   acc_d;
   logic [DATA_WIDTH-1:0] crc_q,   crc_d;
   logic [IDX_W-1:0]      idx_q,   idx_d;
   logic                  error_q, error_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q,  w_done_d;
   logic                  aw_fire, w_fire;

   // Fixed single-beat, full-word write attributes
   assign awid_o    = 4'h0;
   assign wid_o     = 4'h0;
   assign arid_o    = 4'h0;
   assign awlen_o   = 4'h0;
   assign awsize_o  = 3'd2;
   assign awburst_o = 2'b01;
   assign wstrb_o   = 4'hF;
   assign wlast_o   = wvalid_o;

   assign awaddr_o  = ADDR_WIDTH'({idx_q, 2'b00});
   assign wdata_o   = value_q;
   assign crc_o     = crc_q;
   assign error_o   = error_q;
   assign busy_o    = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                      (state_q == S_RADDR) || (state_q == S_RDATA);

   // IDs and read last are not needed: one outstanding transaction at a time
   logic unused_in;
   assign unused_in = ^{bid_i, rid_i, rlast_i};

   // Run state register; asynchronous reset drops every channel at once
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q   <= S_IDLE;
         value_q   <= '0;
         step_q    <= '0;
         acc_q     <= '0;
         crc_q     <= '0;
         idx_q     <= '0;
         error_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         step_q    <= step_d;
         acc_q     <= acc_d;
         crc_q     <= crc_d;
         idx_q     <= idx_d;
         error_q   <= error_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             timeout;
   logic             waiting;

   // Watchdog cycle counter, restarted on every state entry
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) timer_q <= '0;
      else         timer_q <= timer_d;
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

   // Next-state, datapath update and channel handshake outputs
   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      step_d    = step_q;
      acc_d     = acc_q;
      crc_d     = crc_q;
      idx_d     = idx_q;
      error_d   = error_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      awvalid_o = 1'b0;
      wvalid_o  = 1'b0;
      bready_o  = 1'b0;
      arvalid_o = 1'b0;
      araddr_o  = '0;
      rready_o  = 1'b0;
      done_o    = 1'b0;
      aw_fire   = 1'b0;
      w_fire    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               value_d   = seed_i;
               step_d    = step_i;
               idx_d     = '0;
               acc_d     = '0;
               error_d   = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            // Each channel holds valid until its own handshake completes
            awvalid_o = !aw_done_q;
            wvalid_o  = !w_done_q;
            aw_fire   = awvalid_o && awready_i;
            w_fire    = wvalid_o && wready_i;
            aw_done_d = aw_done_q || aw_fire;
            w_done_d  = w_done_q || w_fire;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_WRESP;
            end
         end
         S_WRESP: begin
            bready_o = 1'b1;
            if (bvalid_i) begin
               acc_d   = acc_q ^ value_q;
               value_d = value_q + step_q;
               idx_d   = idx_q + 1'b1;
               if (bresp_i != 2'b00) error_d = 1'b1;
               state_d = (idx_q == IDX_W'(SLOTS - 1)) ? S_RADDR : S_WRITE;
            end
         end
         S_RADDR: begin
            arvalid_o = 1'b1;
            araddr_o  = ADDR_WIDTH'(CRC_ADDR);
            if (arready_i) state_d = S_RDATA;
         end
         S_RDATA: begin
            rready_o = 1'b1;
            if (rvalid_i) begin
               crc_d = rdata_i;
               if (rdata_i != acc_q) error_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef AXI_MASTER_TIMEOUT_EN
      // A stalled handshake is abandoned once the watchdog expires
      waiting = busy_o;
      timeout = waiting && (state_d == state_q) &&
                (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
      if (timeout) begin
         error_d   = 1'b1;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
         state_d   = S_DONE;
      end
      if (state_d != state_q) timer_d = '0;
      else if (waiting)       timer_d = timer_q + 1'b1;
      else                    timer_d = '0;
`endif
   end

endmodule
`default_nettype wire

// File: doc/axi_counter_master.md
Name: axi_counter_master

Overview:
- AXI master stage directly upstream of the register-file slave. It feeds that slave's write, response and read channels.
- On a start pulse it fills SLOTS registers with a counter sequence using single-beat writes.
- It then reads back the slave's XOR checksum location and compares it against a locally accumulated XOR.
- It reports pass/fail and the checksum to the control logic.

Parameters:
- DATA_WIDTH, 32, data bus width; must be 32 (4 strobe bits).
- ADDR_WIDTH, 32, address bus width.
- SLOTS, 8, number of registers written per run (1..8).
- CRC_ADDR, 32'h20, byte address of the slave checksum location (word index 8).
- TIMEOUT_CYCLES, 256, handshake watchdog limit; used only with AXI_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle run request; sampled in IDLE only
- seed_i  in  DATA_WIDTH  first value written; sampled with start_i
- step_i  in  DATA_WIDTH  increment between values; sampled with start_i
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at run end
- error_o  out  1  sticky; cleared by the next accepted start_i
- crc_o  out  DATA_WIDTH  checksum read back from the slave
- awid_o/wid_o/arid_o  out  4  constant 4'h0
- awlen_o  out  4  constant 0 (single beat)
- awsize_o  out  3  constant 3'd2
- awburst_o  out  2  constant 2'b01
- awaddr_o  out  ADDR_WIDTH  write address
- awvalid_o  out  1 / awready_i  in  1
- wdata_o  out  DATA_WIDTH / wstrb_o  out  4  constant 4'hF
- wlast_o  out  1  equal to wvalid_o
- wvalid_o  out  1 / wready_i  in  1
- bid_i  in  4 / bresp_i  in  2 / bvalid_i  in  1 / bready_o  out  1
- araddr_o  out  ADDR_WIDTH / arvalid_o  out  1 / arready_i  in  1
- rid_i  in  4 / rdata_i  in  DATA_WIDTH / rlast_i  in  1 / rvalid_i  in  1 / rready_o  out  1

Behaviour:
- Reset values: all valid outputs 0, bready_o=0, rready_o=0, busy_o=0, done_o=0, error_o=0, crc_o=0, awaddr_o=0, araddr_o=0, wdata_o=0.
- Reset mid-run returns to IDLE immediately. No channel is left asserted.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - start_i=1 latches value=seed_i, step=step_i, idx=0, acc=0; clears error_o.
  - Next cycle enters WRITE with busy_o=1.
  - start_i outside IDLE is ignored.
- WRITE:
  - awvalid_o and wvalid_o rise in the same cycle, with awaddr_o={idx,2'b00} and wdata_o=value.
  - Each valid drops the cycle after its own handshake and never deasserts before it.
  - AW and W may complete in either order or together.
  - When both have completed, move to WRESP.
- WRESP:
  - bready_o=1 in this state only.
  - On bvalid_i: acc ^= value; value += step (modulo 2^DATA_WIDTH); idx++.
  - bresp_i != 2'b00 sets error_o; the run continues.
  - If idx reaches SLOTS-1 on this beat, go to RADDR; otherwise back to WRITE.
- RADDR: arvalid_o=1, araddr_o=CRC_ADDR, held until arready_i; then RDATA.
- RDATA:
  - rready_o=1.
  - On rvalid_i: crc_o=rdata_i; rdata_i != acc sets error_o; go to DONE.
  - rid_i and rlast_i are ignored.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle; return to IDLE.
- Latency with zero-wait slave: 2 cycles per write (WRITE and WRESP, the slave asserts bvalid a cycle after data), plus 2 for the read and 1 for DONE.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter resets on every state entry and increments while waiting in WRITE, WRESP, RADDR or RDATA.
  - Reaching TIMEOUT_CYCLES sets error_o, drops all valids and readies, and forces DONE; done_o still pulses.
- Disabled: no counter exists; the FSM waits indefinitely.

Test Plan:
- seed=1, step=1, zero-wait slave -> writes 1..8 to 0x00..0x1C; read 0x20 returns 0x8; crc_o=0x8, error_o=0, done_o pulses once.
- awready_i held low 5 cycles while wready_i=1 -> W completes first, awvalid_o held stable with same address, and no write is duplicated.
- Slave returns bresp=2'b10 on third write -> error_o=1 after that beat; all 8 writes and the read still occur.
- Slave returns rdata=0x9 instead of 0x8 -> crc_o=0x9, error_o=1.
- areset low during WRESP of write 4 -> all outputs at reset values next edge; a new start with seed=0x10 and step=0 gives crc_o=0x0.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, arready_i stuck at 0 -> error_o=1 and done_o pulse at cycle 16 of RADDR.
